// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: self-synchronising 8-bit LFSR sequence checker with hex error display; LFSR_CHK_SEED_EN adds seed/set load
module lfsr_seq_checker #(
   parameter int LOCK_CNT = 4,
   parameter int MAX_MISS = 3
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef LFSR_CHK_SEED_EN
   input  logic [7:0] seed,
   input  logic       set,
`endif
   input  logic [7:0] din,
   input  logic       din_valid,
   input  logic       clear,
   output logic       locked,
   output logic       err_pulse,
   output logic [7:0] err_cnt,
   output logic [6:0] lowBit,
   output logic [6:0] highBit
);
   typedef enum logic [1:0] {SEEK, TRACK, LOCK} state_t;
   localparam logic [3:0] LC = 4'(LOCK_CNT);
   localparam logic [3:0] MM = 4'(MAX_MISS);
   state_t     state;
   logic [7:0] ref_val;
   logic [7:0] pred;
   logic [3:0] match_cnt;
   logic [3:0] miss_cnt;
   function automatic logic [7:0] nxt(input logic [7:0] x);
      return x == 8'h00 ? 8'h01 : {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
   endfunction
   function automatic logic [6:0] seg(input logic [3:0] h);
      case (h)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
   endfunction
   assign pred    = nxt(ref_val);
   assign locked  = state == LOCK;
   assign lowBit  = seg(err_cnt[3:0]);
   assign highBit = seg(err_cnt[7:4]);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= SEEK;
         ref_val   <= 8'h00;
         match_cnt <= 4'd0;
         miss_cnt  <= 4'd0;
         err_cnt   <= 8'h00;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
`ifdef LFSR_CHK_SEED_EN
         if (set) begin
            ref_val   <= seed;
            state     <= LOCK;
            miss_cnt  <= 4'd0;
            match_cnt <= 4'd0;
         end else
`endif
         if (din_valid) begin
            case (state)
               TRACK: begin
                  ref_val   <= din;
                  match_cnt <= din == pred ? match_cnt + 4'd1 : 4'd0;
                  if (din == pred && match_cnt + 4'd1 == LC) begin
                     state    <= LOCK;
                     miss_cnt <= 4'd0;
                  end
               end
               LOCK: begin
                  // flywheel: prediction advances regardless of the received byte
                  ref_val <= pred;
                  if (din == pred) miss_cnt <= 4'd0;
                  else begin
                     err_pulse <= 1'b1;
                     err_cnt   <= err_cnt + {7'd0, err_cnt != 8'hFF};
                     miss_cnt  <= miss_cnt + 4'd1;
                     if (miss_cnt + 4'd1 == MM) begin
                        state     <= SEEK;
                        miss_cnt  <= 4'd0;
                        match_cnt <= 4'd0;
                     end
                  end
               end
               default: begin
                  ref_val   <= din;
                  match_cnt <= 4'd0;
                  state     <= TRACK;
               end
            endcase
         end
         if (clear) err_cnt <= 8'h00;
      end
   end
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb_lfsr_seq_checker: directed and randomized checks of lfsr_seq_checker against a behavioural model
module tb_lfsr_seq_checker;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       din_valid = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] din = 8'h00;
`ifdef LFSR_CHK_SEED_EN
   logic       set = 1'b0;
   logic [7:0] seed = 8'h00;
`endif
   logic       locked, err_pulse;
   logic [7:0] err_cnt;
   logic [6:0] lowBit, highBit;
   int checks = 0;
   int failures = 0;
   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   lfsr_seq_checker #(.LOCK_CNT(4), .MAX_MISS(3)) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef LFSR_CHK_SEED_EN
      .seed(seed),
      .set(set),
`endif
      .din(din),
      .din_valid(din_valid),
      .clear(clear),
      .locked(locked),
      .err_pulse(err_pulse),
      .err_cnt(err_cnt),
      .lowBit(lowBit),
      .highBit(highBit)
   );
   always #5 clk = ~clk;
   function automatic logic [7:0] nx(input logic [7:0] x);
      return x == 8'h00 ? 8'h01 : {^(x & 8'h1D), x[7:1]};
   endfunction
   // model: mode 0 = searching, 1 = acquiring, 2 = locked
   int         m_mode = 0;
   int         m_good = 0;
   int         m_bad = 0;
   logic [7:0] m_ref = 8'h00;
   logic [7:0] m_err = 8'h00;
   logic       m_pulse = 1'b0;
   always @(posedge clk) begin
      logic [7:0] e;
      e = nx(m_ref);
      m_pulse = 1'b0;
      if (!rst_n) begin
         m_mode = 0; m_good = 0; m_bad = 0; m_ref = 8'h00; m_err = 8'h00;
      end else begin
`ifdef LFSR_CHK_SEED_EN
         if (set) begin
            m_mode = 2; m_ref = seed; m_good = 0; m_bad = 0;
         end else
`endif
         if (din_valid) begin
            if (m_mode == 0) begin
               m_ref = din; m_good = 0; m_mode = 1;
            end else if (m_mode == 1) begin
               m_good = din == e ? m_good + 1 : 0;
               m_ref = din;
               if (m_good == 4) begin m_mode = 2; m_bad = 0; end
            end else begin
               m_ref = e;
               if (din == e) m_bad = 0;
               else begin
                  m_pulse = 1'b1;
                  m_err = m_err == 8'hFF ? 8'hFF : m_err + 8'h01;
                  m_bad++;
                  if (m_bad == 3) begin m_mode = 0; m_bad = 0; m_good = 0; end
               end
            end
         end
         if (clear) m_err = 8'h00;
      end
   end
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic cmp();
      chk("model_locked", {7'd0, locked}, {7'd0, m_mode == 2});
      chk("model_err_pulse", {7'd0, err_pulse}, {7'd0, m_pulse});
      chk("model_err_cnt", err_cnt, m_err);
      chk("model_lowBit", {1'b0, lowBit}, {1'b0, seg_tab[m_err[3:0]]});
      chk("model_highBit", {1'b0, highBit}, {1'b0, seg_tab[m_err[7:4]]});
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cmp();
   endtask
   task automatic drive(input logic v, input logic [7:0] d, input logic c);
      din_valid = v; din = d; clear = c;
      tick();
   endtask
   logic [7:0] g;
   task automatic good();
      g = nx(g);
      drive(1'b1, g, 1'b0);
   endtask
   task automatic bad(input logic c);
      g = nx(g);
      drive(1'b1, g ^ 8'h5A, c);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      g = 8'h00;
   endtask
   initial begin
      g = 8'h00;
      do_reset();
      chk("rst_locked", {7'd0, locked}, 8'h00);
      chk("rst_err_cnt", err_cnt, 8'h00);
      chk("rst_lowBit", {1'b0, lowBit}, 8'b01000000);
      chk("rst_highBit", {1'b0, highBit}, 8'b01000000);
      for (int i = 0; i < 5; i++) begin
         good();
         if (i < 4) chk("acq_not_locked", {7'd0, locked}, 8'h00);
      end
      chk("acq_sample", din, 8'h10);
      chk("acq_locked", {7'd0, locked}, 8'h01);
      chk("acq_err_cnt", err_cnt, 8'h00);
      g = nx(g);
      drive(1'b1, 8'h00, 1'b0);
      chk("fly_pulse", {7'd0, err_pulse}, 8'h01);
      chk("fly_err_cnt", err_cnt, 8'h01);
      drive(1'b1, 8'hC4, 1'b0);
      drive(1'b1, 8'hE2, 1'b0);
      drive(1'b1, 8'h71, 1'b0);
      g = 8'h71;
      chk("fly_err_after", err_cnt, 8'h01);
      chk("fly_lowBit", {1'b0, lowBit}, 8'b01111001);
      chk("fly_highBit", {1'b0, highBit}, 8'b01000000);
      chk("fly_locked", {7'd0, locked}, 8'h01);
      for (int i = 0; i < 3; i++) begin
         g = nx(g);
         drive(1'b1, 8'hFF, 1'b0);
         chk("loss_locked", {7'd0, locked}, i < 2 ? 8'h01 : 8'h00);
      end
      chk("loss_err_cnt", err_cnt, 8'h04);
      good();
      chk("loss_retrack", {7'd0, locked}, 8'h00);
      do_reset();
      for (int i = 0; i < 5; i++) begin
         repeat ($urandom_range(1, 3)) drive(1'b0, 8'($urandom), 1'b0);
         good();
         chk("gap_locked", {7'd0, locked}, i < 4 ? 8'h00 : 8'h01);
      end
      do_reset();
      drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'h00, 1'b0);
      drive(1'b1, 8'h01, 1'b0);
      drive(1'b1, 8'h80, 1'b0);
      drive(1'b1, 8'h40, 1'b0);
      chk("zero_not_locked", {7'd0, locked}, 8'h00);
      drive(1'b1, 8'h20, 1'b0);
      chk("zero_locked", {7'd0, locked}, 8'h01);
      do_reset();
      repeat (110) begin
         repeat (5) good();
         repeat (3) bad(1'b0);
      end
      chk("sat_err_cnt", err_cnt, 8'hFF);
      chk("sat_lowBit", {1'b0, lowBit}, 8'b00001110);
      chk("sat_highBit", {1'b0, highBit}, 8'b00001110);
      repeat (5) good();
      bad(1'b1);
      chk("clr_err_cnt", err_cnt, 8'h00);
      chk("clr_pulse", {7'd0, err_pulse}, 8'h01);
      chk("clr_locked", {7'd0, locked}, 8'h01);
      rst_n = 1'b0;
      g = nx(g);
      drive(1'b1, g, 1'b0);
      rst_n = 1'b1;
      chk("midrst_locked", {7'd0, locked}, 8'h00);
      chk("midrst_pulse", {7'd0, err_pulse}, 8'h00);
      chk("midrst_err_cnt", err_cnt, 8'h00);
      chk("midrst_lowBit", {1'b0, lowBit}, 8'b01000000);
`ifdef LFSR_CHK_SEED_EN
      seed = 8'h10; set = 1'b1;
      drive(1'b1, 8'h33, 1'b0);
      set = 1'b0;
      chk("seed_locked", {7'd0, locked}, 8'h01);
      drive(1'b1, 8'h88, 1'b0);
      chk("seed_match_locked", {7'd0, locked}, 8'h01);
      chk("seed_err_cnt", err_cnt, 8'h00);
      chk("seed_pulse", {7'd0, err_pulse}, 8'h00);
`endif
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic v;
         logic c;
         logic [7:0] d;
         if ($urandom_range(0, 999) == 0) do_reset();
         v = $urandom_range(0, 3) != 0;
         c = $urandom_range(0, 63) == 0;
         d = 8'($urandom);
         if (v) begin
            g = nx(g);
            d = $urandom_range(0, 7) == 0 ? g ^ 8'($urandom_range(1, 255)) : g;
         end
`ifdef LFSR_CHK_SEED_EN
         if ($urandom_range(0, 299) == 0) begin
            seed = 8'($urandom);
            set = 1'b1;
            g = seed;
         end
`endif
         drive(v, d, c);
`ifdef LFSR_CHK_SEED_EN
         set = 1'b0;
`endif
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Receive-side counterpart of the 8-bit LFSR pattern generator.
- Accepts one byte per valid cycle from the generator's state output, self-synchronises to the sequence, then predicts each following value.
- Counts mismatches and shows the 8-bit error count in hex on two active-low 7-segment digits.
- Used on the board as a loopback checker for the generator and for any link carrying its sequence.

Parameters:
- LOCK_CNT, 4: consecutive correct predictions required to go from TRACK to LOCK (range 1..15).
- MAX_MISS, 3: consecutive mispredictions in LOCK that drop the block back to SEEK (range 1..15).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- din  input  8  received sequence byte.
- din_valid  input  1  din is valid this cycle; one sample is consumed per valid cycle.
- clear  input  1  synchronous clear of err_cnt only.
- locked  output  1  high while state is LOCK.
- err_pulse  output  1  one-cycle pulse per counted mismatch.
- err_cnt  output  8  saturating mismatch count.
- lowBit  output  7  active-low segments, err_cnt[3:0].
- highBit  output  7  active-low segments, err_cnt[7:4].

Behaviour:
- Next-value function nxt(x): if x==0 then 8'h01, else {x[4]^x[3]^x[2]^x[0], x[7:1]}. This matches the generator bit-exactly.
- Registers: state (SEEK/TRACK/LOCK), ref[7:0], match_cnt[3:0], miss_cnt[3:0], err_cnt[7:0], err_pulse.
- Reset (rst_n=0 at edge): state=SEEK, ref=0, match_cnt=0, miss_cnt=0, err_cnt=0, err_pulse=0, locked=0.
- At reset, both digits show 0: lowBit=highBit=7'b1000000.
- Cycles with din_valid=0 leave all state unchanged and drive err_pulse=0.
- SEEK, on a valid sample: ref=din, match_cnt=0, go to TRACK.
- TRACK, valid sample with din==nxt(ref): ref=din, match_cnt+1. If match_cnt+1==LOCK_CNT, go to LOCK and clear miss_cnt.
- TRACK, valid sample with din!=nxt(ref): ref=din, match_cnt=0, stay in TRACK. No error is counted in SEEK or TRACK.
- LOCK, any valid sample: ref=nxt(ref) (flywheel), so a corrupted sample does not break prediction.
- LOCK match: miss_cnt=0.
- LOCK mismatch:
  - err_pulse=1 for exactly that cycle.
  - err_cnt+1, saturating at 8'hFF.
  - miss_cnt+1. If miss_cnt+1==MAX_MISS, go to SEEK and clear miss_cnt and match_cnt.
- Latency: locked, err_pulse and err_cnt are registered and update on the edge that consumes the sample. lowBit and highBit decode err_cnt combinationally.
- clear=1 sets err_cnt=0 and leaves state, ref and the counters unchanged. If clear and a mismatch land in the same cycle, clear wins (err_cnt=0), but err_pulse still fires.
- rst_n=0 overrides every other input, including mid-lock.
- Segment table, active-low, bit order gfedcba:
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000
  - 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000
  - 8 → 0000000, 9 → 0010000, A → 0001000, b → 0000011
  - C → 1000110, d → 0100001, E → 0000110, F → 0001110

Optional Feature:
- Macro: LFSR_CHK_SEED_EN.
- Defined: adds ports seed input 8 and set input 1.
  - set=1 at an edge: ref=seed, state=LOCK, miss_cnt=0, match_cnt=0. This mirrors the generator's seed load and allows immediate checking without acquisition.
  - set takes priority over din_valid; a sample presented in the same cycle is ignored.
  - rst_n still has priority over set.
- Undefined: the seed and set ports do not exist, and LOCK is reachable only through SEEK/TRACK.

Test Plan:
1. Acquisition:
   - Stimulus: reset, then valid samples 01,80,40,20,10 on consecutive cycles.
   - Response: locked=0 through the 4th edge, locked=1 after the 5th edge, err_cnt=00.
2. Single-error flywheel:
   - Stimulus: after test 1, send 00 where 88 is expected, then C4,E2,71.
   - Response: one err_pulse, err_cnt=01, lowBit=1111001, highBit=1000000, locked stays 1, no further errors.
3. Loss of lock:
   - Stimulus: while locked, send 3 consecutive wrong bytes (FF,FF,FF).
   - Response: err_cnt +3, locked=0 after the 3rd edge; the next valid sample re-enters TRACK.
4. Valid gaps and zero state:
   - Stimulus: interleave din_valid=0 cycles in the test 1 sequence.
   - Response: identical lock timing counted in valid samples only.
   - Stimulus: feed 00 then 01 in TRACK.
   - Response: counted as a match (nxt(00)=01).
5. Saturation and clear:
   - Stimulus: force 300 mismatches with periodic relock.
   - Response: err_cnt holds FF, both digits show 0001110.
   - Stimulus: clear=1 coincident with a mismatch.
   - Response: err_cnt=00, err_pulse=1.
6. Reset and seed (LFSR_CHK_SEED_EN):
   - Stimulus: rst_n=0 mid-LOCK.
   - Response: all outputs at reset values next cycle.
   - Stimulus: set=1 with seed=10 and din_valid=1 in the same cycle, then 88.
   - Response: locked=1 immediately, 88 counted as a match, err_cnt=00.
